cpu_input_conditioner: RTL and testbench



---
 rtl/cpu_input_conditioner.sv | 194 +++++++++++++++++++
 tb/tb_cpu_input_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_input_conditioner.sv
// Synchronizes and debounces the CPU ready button, emits one strobe per press and a coherent switch snapshot.
// Optional per-bit switch debounce: define CPU_INPUT_COND_SW_DEBOUNCE_EN.
module cpu_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SW_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                ready_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                ready_out,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic [7:0]          press_count,
  output logic                btn_state
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [SYNC_STAGES-1:0]               ready_sync_q, ready_sync_d;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic                                 ready_s;
  logic [SW_WIDTH-1:0]                  sw_s;
  logic [SW_WIDTH-1:0]                  sw_snap;

  state_e                               state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic                                 fire;

  logic                                 ready_out_q, ready_out_d;
  logic [SW_WIDTH-1:0]                  sw_out_q, sw_out_d;
  logic [7:0]                           press_count_q, press_count_d;

  always_comb begin
    ready_sync_d = {ready_sync_q[SYNC_STAGES-2:0], ready_raw};
    sw_sync_d    = {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
    ready_s      = ready_sync_q[SYNC_STAGES-1];
    sw_s         = sw_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ready_sync_q <= '0;
      sw_sync_q    <= '0;
    end else begin
      ready_sync_q <= ready_sync_d;
      sw_sync_q    <= sw_sync_d;
    end
  end

`ifdef CPU_INPUT_COND_SW_DEBOUNCE_EN
  logic [SW_WIDTH-1:0]         sw_stable_q, sw_stable_d;
  logic [SW_WIDTH-1:0][CW-1:0] sw_cnt_q, sw_cnt_d;

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = sw_cnt_q;
    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      if (sw_s[i] == sw_stable_q[i]) begin
        sw_cnt_d[i] = '0;
      end else if (sw_cnt_q[i] == CNT_LAST) begin
        sw_stable_d[i] = sw_s[i];
        sw_cnt_d[i]    = '0;
      end else begin
        sw_cnt_d[i] = sw_cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sw_stable_q <= '0;
      sw_cnt_q    <= '0;
    end else begin
      sw_stable_q <= sw_stable_d;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  always_comb sw_snap = sw_stable_q;
`else
  always_comb sw_snap = sw_s;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ready_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!ready_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!ready_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (ready_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only an entry into PRESSED from the press side fires; release bounce re-entry does not.
  always_comb begin
    btn_state = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    fire      = (state_d == PRESSED) && ((state_q == IDLE) || (state_q == PRESS_WAIT));
  end

  always_comb begin
    ready_out_d   = fire;
    sw_out_d      = sw_out_q;
    press_count_d = press_count_q;
    if (fire) begin
      sw_out_d      = sw_snap;
      press_count_d = press_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ready_out_q   <= 1'b0;
      sw_out_q      <= '0;
      press_count_q <= '0;
    end else begin
      ready_out_q   <= ready_out_d;
      sw_out_q      <= sw_out_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    ready_out   = ready_out_q;
    sw_out      = sw_out_q;
    press_count = press_count_q;
  end

endmodule

// File: tb/tb_cpu_input_conditioner.sv
// Scoreboard bench for cpu_input_conditioner: predicted strobes (cycle, snapshot, count) are queued
// when a press is driven and matched against every ready_out pulse.
module tb_cpu_input_conditioner;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         ready_raw;
  logic [W-1:0] sw_raw;
  logic         ready_out;
  logic [W-1:0] sw_out;
  logic [7:0]   press_count;
  logic         btn_state;

  cpu_input_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .SW_WIDTH        (W)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .ready_raw   (ready_raw),
    .sw_raw      (sw_raw),
    .ready_out   (ready_out),
    .sw_out      (sw_out),
    .press_count (press_count),
    .btn_state   (btn_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sw;
    logic [7:0]   cnt;
    int unsigned  cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got_e;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_count = 8'd0;
  int unsigned mark;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge where ready_raw goes (and stays) high.
  task automatic expect_strobe(input logic [W-1:0] sw);
    exp_t t;
    model_count = model_count + 8'd1;
    t.sw  = sw;
    t.cnt = model_count;
    t.cyc = cyc + S + D;
    exp_q.push_back(t);
  endtask

  task automatic press(input logic [W-1:0] sw, input int unsigned hold, input int unsigned rel);
    sw_raw    = sw;
    ready_raw = 1'b1;
    expect_strobe(sw);
    tick(hold);
    ready_raw = 1'b0;
    tick(rel);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    tick(2);
    n_reset = 1'b1;
    model_count = 8'd0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        check("strobe_missing", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (ready_out !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", ready_out, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("strobe_cycle", cyc, got_e.cyc);
          check("sw_out", sw_out, got_e.sw);
          check("press_count", press_count, got_e.cnt);
          check("btn_at_strobe", btn_state, 1);
        end
      end
    end
  end

  initial begin
    n_reset   = 1'b0;
    ready_raw = 1'b0;
    sw_raw    = '0;
    tick(3);
    check("rst_ready_out", ready_out, 0);
    check("rst_sw_out", sw_out, 0);
    check("rst_press_count", press_count, 0);
    check("rst_btn_state", btn_state, 0);
    n_reset = 1'b1;
    tick(2);

    // Clean press, held 20 cycles.
    mark = cyc;
    sw_raw    = 8'hA5;
    ready_raw = 1'b1;
    expect_strobe(8'hA5);
    tick(S + D - 1);
    check("clean_btn_before", btn_state, 0);
    check("clean_ready_before", ready_out, 0);
    tick(1);
    check("clean_btn_pressed", btn_state, 1);
    tick(20 - (S + D));
    check("clean_sw_hold", sw_out, 8'hA5);
    check("clean_count", press_count, 1);
    ready_raw = 1'b0;
    tick(10);
    check("clean_btn_released", btn_state, 0);

    // Bouncy press then clean hold; run of two highs must not fire.
    do_reset();
    sw_raw = 8'h5A;
    ready_raw = 1'b1; tick(1);
    ready_raw = 1'b0; tick(1);
    ready_raw = 1'b1; tick(2);
    ready_raw = 1'b0; tick(1);
    ready_raw = 1'b1;
    expect_strobe(8'h5A);
    tick(12);
    check("bounce_count", press_count, 1);

    // Release bounce 0,1,0 then steady low: no second strobe.
    ready_raw = 1'b0; tick(1);
    ready_raw = 1'b1; tick(1);
    ready_raw = 1'b0;
    tick(S + D - 1);
    check("rel_btn_still", btn_state, 1);
    tick(1);
    check("rel_btn_low", btn_state, 0);
    tick(4);
    press(8'h11, 8, 10);
    check("rel_next_count", press_count, 2);

    // Switches change after the strobe: snapshot must hold.
    sw_raw    = 8'h3C;
    ready_raw = 1'b1;
    expect_strobe(8'h3C);
    tick(8);
    sw_raw = 8'hC3;
    tick(5);
    check("snap_hold", sw_out, 8'h3C);
    ready_raw = 1'b0;
    tick(10);
    check("snap_after_release", sw_out, 8'h3C);
    press(8'hC3, 8, 10);
    check("snap_next", sw_out, 8'hC3);

    // Reset asserted in PRESS_WAIT with cnt=2, button held throughout.
    sw_raw    = 8'h77;
    ready_raw = 1'b1;
    tick(S + 2);
    n_reset = 1'b0;
    tick(1);
    check("midrst_ready_out", ready_out, 0);
    check("midrst_sw_out", sw_out, 0);
    check("midrst_count", press_count, 0);
    check("midrst_btn", btn_state, 0);
    n_reset = 1'b1;
    model_count = 8'd0;
    expect_strobe(8'h77);
    tick(12);
    ready_raw = 1'b0;
    tick(10);
    check("midrst_count_after", press_count, 1);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 256; i++) press(8'(i), 8, 8);
    check("wrap_zero", press_count, 0);
    press(8'hFF, 8, 8);
    check("wrap_one", press_count, 1);

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
